game_judge: RTL

GAME_JUDGE -- requirements
Module: game_judge

---
 rtl/game_pkg.sv | 17 +
 rtl/cell_overlap.sv | 34 +++
 rtl/game_judge.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and default parameter values for the game judge.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } judge_state_t;

  localparam int DEF_ROWS        = 16;
  localparam int DEF_COLS        = 2;
  localparam int DEF_SCORE_W     = 8;
  localparam int DEF_LIVES       = 3;
  localparam int DEF_GRACE_TICKS = 4;

endpackage

// File: rtl/cell_overlap.sv
// Combinational overlap detector between the bird map and the pipe map.
// Column 0 is the bird column; column 1 is the column the pipe has just left.
module cell_overlap
  import game_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input  logic [ROWS*COLS-1:0] play_field_i,
  input  logic [ROWS*COLS-1:0] pipe_i,
  output logic                 collision_o,
  output logic                 fall_o,
  output logic                 pass_o
);

  logic col0_any;
  logic col1_any;

  // OR-reduce the pipe bits of column 0 and column 1 across all rows
  always_comb begin
    col0_any = 1'b0;
    col1_any = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      col0_any = col0_any | pipe_i[r*COLS];
      col1_any = col1_any | pipe_i[r*COLS + 1];
    end
  end

  assign collision_o = |(pipe_i & play_field_i);
  assign fall_o      = ~|play_field_i;
  // A pipe counts as passed once it sits wholly behind the bird column.
  assign pass_o      = col1_any & ~col0_any;

endmodule

// File: rtl/game_judge.sv
// Game judge: tracks lives, score and invulnerability for a flappy-style game.
// Optional feature: define GAME_JUDGE_HISCORE_EN to add the hi_score output,
// which keeps the best score across restarts until reset.
module game_judge
  import game_pkg::*;
#(
  parameter int ROWS        = DEF_ROWS,
  parameter int COLS        = DEF_COLS,
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int LIVES       = DEF_LIVES,
  parameter int GRACE_TICKS = DEF_GRACE_TICKS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 start_game,
  input  logic [ROWS*COLS-1:0] play_field,
  input  logic [ROWS*COLS-1:0] pipe,
  output logic                 gameover,
  output logic                 score_pulse,
  output logic [SCORE_W-1:0]   score,
  output logic [2:0]           lives_left,
  output logic                 invuln
`ifdef GAME_JUDGE_HISCORE_EN
  ,
  output logic [SCORE_W-1:0]   hi_score
`endif
);

  localparam int               GRACE_W    = $clog2(GRACE_TICKS + 1);
  localparam logic [2:0]       LIVES_INIT = 3'(LIVES);
  localparam logic [GRACE_W-1:0] GRACE_INIT = GRACE_W'(GRACE_TICKS);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

  judge_state_t        state_q, state_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic                pulse_q, pulse_d;
  logic [2:0]          lives_q, lives_d;
  logic [GRACE_W-1:0]  grace_q, grace_d;
  logic                pass_hist_q, pass_hist_d;
  logic                start_q;

  logic collision;
  logic fall;
  logic pass;
  logic start_edge;
  logic pass_edge;
  logic game_load;
  logic in_play;

  cell_overlap #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_overlap (
    .play_field_i (play_field),
    .pipe_i       (pipe),
    .collision_o  (collision),
    .fall_o       (fall),
    .pass_o       (pass)
  );

  assign start_edge = start_game & ~start_q;
  assign pass_edge  = pass & ~pass_hist_q;
  assign in_play    = (state_q == RUN) || (state_q == HIT);
  // Starting is level-sensitive from IDLE but needs a fresh press from OVER,
  // so a held start button does not immediately relaunch a lost game.
  // Neither start condition waits for a tick.
  assign game_load  = ((state_q == IDLE) && start_game) ||
                      ((state_q == OVER) && start_edge);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; in-game transitions only advance on tick
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_game) state_d = RUN;
      OVER: if (start_edge) state_d = RUN;
      RUN: begin
        if (tick) begin
          if (fall)                       state_d = OVER;
          else if (collision)             state_d = (lives_q == 3'd1) ? OVER : HIT;
        end
      end
      HIT: begin
        if (tick) begin
          if (fall)                       state_d = OVER;
          else if (grace_q <= GRACE_W'(1)) state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Score, lives, grace and pass-history updates for the coming clock
  always_comb begin
    score_d     = score_q;
    pulse_d     = 1'b0;
    lives_d     = lives_q;
    grace_d     = grace_q;
    pass_hist_d = pass_hist_q;
    if (game_load) begin
      score_d     = '0;
      lives_d     = LIVES_INIT;
      grace_d     = '0;
      pass_hist_d = 1'b0;
    end else if (in_play && tick) begin
      pass_hist_d = pass;
      if (!fall) begin
        // A pass edge and a collision on the same tick both count.
        if (pass_edge) begin
          pulse_d = 1'b1;
          if (score_q != SCORE_MAX) score_d = score_q + SCORE_W'(1);
        end
        if ((state_q == RUN) && collision) begin
          if (lives_q == 3'd1) begin
            lives_d = 3'd0;
          end else begin
            lives_d = lives_q - 3'd1;
            grace_d = GRACE_INIT;
          end
        end else if ((state_q == HIT) && (grace_q != '0)) begin
          grace_d = grace_q - GRACE_W'(1);
        end
      end
    end
  end

  // Datapath registers and start-button history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score_q     <= '0;
      pulse_q     <= 1'b0;
      lives_q     <= LIVES_INIT;
      grace_q     <= '0;
      pass_hist_q <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      score_q     <= score_d;
      pulse_q     <= pulse_d;
      lives_q     <= lives_d;
      grace_q     <= grace_d;
      pass_hist_q <= pass_hist_d;
      start_q     <= start_game;
    end
  end

`ifdef GAME_JUDGE_HISCORE_EN
  logic [SCORE_W-1:0] hi_q;

  // Best score survives restarts; only reset clears it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
    end else if (score_q > hi_q) begin
      hi_q <= score_q;
    end
  end

  assign hi_score = hi_q;
`endif

  assign gameover    = (state_q == OVER);
  assign invuln      = (state_q == HIT);
  assign score       = score_q;
  assign score_pulse = pulse_q;
  assign lives_left  = lives_q;

endmodule
